program_loader: RTL

Synthesizable replacement for the bench-side binary file loader: accepts a byte stream (UART/debug link), packs bytes into instruction words with selectable byte order, writes them into instruction memory through a write/acknowledge port, and holds the CPU until the image is complete. It sits between the byte-source peripheral and the instruction memory write port. It also drives the CPU core's hold input.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/loader_word_assembler.sv | 61 ++++++
 rtl/program_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states, byte order and word geometry.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4
   } loader_state_t;

   typedef enum logic {
      ORDER_LITTLE = 1'b0,
      ORDER_BIG    = 1'b1
   } byte_order_t;

   function automatic int bytes_per_word(input int word_width);
      return word_width / 8;
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs a byte stream into one word with selectable byte order; flags the byte that completes it.
// The next-word output only exists when LOADER_CHECKSUM_EN is defined (trailer compare).
module loader_word_assembler
   import loader_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   input  logic                  order_i,
   output logic [WORD_WIDTH-1:0] word_o,
`ifdef LOADER_CHECKSUM_EN
   output logic [WORD_WIDTH-1:0] word_next_o,
`endif
   output logic                  last_byte_o
);

   localparam int BPW = bytes_per_word(WORD_WIDTH);
   localparam int CW  = $clog2(BPW);

   logic [CW-1:0]         count_q, count_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;

   assign last_byte_o = byte_valid_i && !clear_i && (count_q == CW'(BPW - 1));
   assign word_o      = word_q;
`ifdef LOADER_CHECKSUM_EN
   assign word_next_o = word_d;
`endif

   // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
   always_comb begin
      word_d  = word_q;
      count_d = count_q;
      if (clear_i) begin
         word_d  = '0;
         count_d = '0;
      end else if (byte_valid_i) begin
         if (order_i == ORDER_BIG) begin
            word_d[WORD_WIDTH - 8 - 8 * int'(count_q) +: 8] = byte_data_i;
         end else begin
            word_d[8 * int'(count_q) +: 8] = byte_data_i;
         end
         count_d = last_byte_o ? '0 : count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         word_q  <= '0;
         count_q <= '0;
      end else begin
         word_q  <= word_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Byte-stream image loader: packs bytes into words, writes them via a write/ack port, holds the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word after the image.
module program_loader
   import loader_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 1024,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [15:0]           length,
   input  logic                  big_endian,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   localparam int                  BYTES_PER_WORD = bytes_per_word(WORD_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BASE         = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(BYTES_PER_WORD);

   loader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           words_q, words_d;
   logic [15:0]           len_q, len_d;
   logic                  order_q, order_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] sum_q, sum_d;
   logic [WORD_WIDTH-1:0] asm_word_next;
`endif

   logic start_ok;
   logic byte_accept;
   logic asm_last;

   assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
   assign in_ready    = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
`else
   assign in_ready    = (state_q == ST_COLLECT);
`endif
   assign byte_accept = in_valid && in_ready;
   assign mem_we      = (state_q == ST_WRITE);
   assign mem_addr    = addr_q;
   assign cpu_hold    = !(state_q == ST_DONE && !error_q);
   assign done        = done_q;
   assign error       = error_q;
   assign words_loaded = words_q;

   // The trailer reuses the image assembler; a new start clears any stale lanes.
   loader_word_assembler #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_assembler (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (start_ok),
      .byte_valid_i (byte_accept),
      .byte_data_i  (in_data),
      .order_i      (order_q),
      .word_o       (mem_wdata),
`ifdef LOADER_CHECKSUM_EN
      .word_next_o  (asm_word_next),
`endif
      .last_byte_o  (asm_last)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      words_d = words_q;
      len_d   = len_q;
      order_d = order_q;
      done_d  = done_q;
      error_d = error_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               addr_d  = BASE;
               words_d = '0;
               len_d   = length;
               order_d = big_endian;
               done_d  = 1'b0;
               error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               if (length == 16'd0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (32'(length) > 32'(DEPTH)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (asm_last) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ack) begin
               words_d = words_q + 16'd1;
               addr_d  = addr_q + ADDR_STEP;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = sum_q + mem_wdata;
`endif
               if (words_q + 16'd1 < len_q) begin
                  state_d = ST_COLLECT;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_DONE;
                  done_d  = 1'b1;
`endif
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (asm_last) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               error_d = (asm_word_next != sum_q);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE;
         words_q <= '0;
         len_q   <= '0;
         order_q <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         len_q   <= len_d;
         order_q <= order_d;
         done_q  <= done_d;
         error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule
